// File: rtl/audio_sample_source_if.sv
// Handshake/bus bundle between the audio sample source and its environment.
// master = the sample source, slave = trigger/ROM/downstream side.
interface audio_sample_source_if #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 2,
  parameter int ADDR_W = 8
);
  logic                     sample_tr;
  logic [1:0]               mode;
  logic [N_CH*DATA_W-1:0]   ext_data;
  logic [ADDR_W-1:0]        tone_step;
  logic [ADDR_W-1:0]        rom_addr;
  logic                     rom_ck;
  logic [DATA_W-1:0]        rom_q;
  logic [N_CH*DATA_W-1:0]   data_out;
  logic                     data_valid;
  logic                     data_ready;
  logic                     overrun;
  logic [2:0]               st;

  modport master (
    input  sample_tr, mode, ext_data, tone_step, rom_q, data_ready,
    output rom_addr, rom_ck, data_out, data_valid, overrun, st
  );

  modport slave (
    output sample_tr, mode, ext_data, tone_step, rom_q, data_ready,
    input  rom_addr, rom_ck, data_out, data_valid, overrun, st
  );
endinterface

// File: rtl/audio_sample_source.sv
// N-channel audio frame source: external data, sine-ROM tone or silence, valid/ready out.
// Tone generation is compiled in only when AUDIO_SRC_TONE_EN is defined.
module audio_sample_source #(
  parameter int DATA_W      = 16,
  parameter int N_CH        = 2,
  parameter int TABLE_DEPTH = 194,
  parameter int ADDR_W      = 8,
  parameter int ROM_LAT     = 1
) (
  input  logic                  i_mclk,
  input  logic                  i_reset,
  audio_sample_source_if.master io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3
  } state_t;

  state_t                 r_st, w_st_nxt;
  logic                   r_tr_d1;
  logic                   w_trig, w_accept, w_take, w_tone;
  logic                   w_wait_last;
  logic [N_CH*DATA_W-1:0] w_rom_frame;
  logic [N_CH*DATA_W-1:0] r_data;
  logic                   r_valid, r_overrun;
  logic                   w_rom_ck;
  logic [ADDR_W-1:0]      w_rom_addr;

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) r_tr_d1 <= 1'b0;
    else         r_tr_d1 <= io_bus.sample_tr;
  end

  assign w_trig   = io_bus.sample_tr & ~r_tr_d1;
  assign w_accept = (r_st == S_HOLD) & r_valid & io_bus.data_ready;
  // A trigger coinciding with acceptance starts the next frame straight away.
  assign w_take   = w_trig & ((r_st == S_IDLE) | w_accept);

`ifdef AUDIO_SRC_TONE_EN
  localparam logic [ADDR_W:0] LP_DEPTH    = (ADDR_W+1)'(TABLE_DEPTH);
  localparam logic [ADDR_W:0] LP_MAX_STEP = (ADDR_W+1)'(TABLE_DEPTH - 1);
  localparam logic [2:0]      LP_LAST     = 3'(ROM_LAT - 1);

  logic [2:0]        r_wcnt;
  logic [ADDR_W-1:0] r_rom_addr, w_addr_nxt;
  logic [ADDR_W:0]   w_step, w_sum;

  assign w_tone      = (io_bus.mode == 2'd1);
  assign w_wait_last = (r_st == S_WAIT) && (r_wcnt == LP_LAST);
  assign w_rom_addr  = r_rom_addr;

  // One bit of headroom keeps addr+step exact before the wrap subtraction.
  always_comb begin
    w_step = ({1'b0, io_bus.tone_step} > LP_MAX_STEP) ? LP_MAX_STEP : {1'b0, io_bus.tone_step};
    w_sum  = {1'b0, r_rom_addr} + w_step;
    w_addr_nxt = (w_sum >= LP_DEPTH) ? ADDR_W'(w_sum - LP_DEPTH) : w_sum[ADDR_W-1:0];
  end

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_wcnt     <= '0;
      r_rom_addr <= '0;
    end else begin
      r_wcnt <= (r_st == S_WAIT) ? r_wcnt + 3'd1 : 3'd0;
      if (w_wait_last) r_rom_addr <= w_addr_nxt;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    assign w_rom_frame[ch*DATA_W +: DATA_W] = io_bus.rom_q;
  end
`else
  logic w_unused_tone;
  assign w_unused_tone = ^{io_bus.tone_step, io_bus.rom_q};
  assign w_tone        = 1'b0;
  assign w_wait_last   = 1'b0;
  assign w_rom_frame   = '0;
  assign w_rom_addr    = '0;
`endif

  // FSM: state register
  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) r_st <= S_IDLE;
    else         r_st <= w_st_nxt;
  end

  // FSM: next state
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE:  if (w_trig) w_st_nxt = w_tone ? S_FETCH : S_HOLD;
`ifdef AUDIO_SRC_TONE_EN
      S_FETCH: w_st_nxt = S_WAIT;
      S_WAIT:  if (w_wait_last) w_st_nxt = S_HOLD;
`endif
      S_HOLD: begin
        if (w_accept) begin
          if (w_take) w_st_nxt = w_tone ? S_FETCH : S_HOLD;
          else        w_st_nxt = S_IDLE;
        end
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_rom_ck = 1'b0;
`ifdef AUDIO_SRC_TONE_EN
    w_rom_ck = (r_st == S_FETCH);
`endif
  end

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_trig & ~w_take;
      if (w_take & ~w_tone) begin
        r_valid <= 1'b1;
        r_data  <= (io_bus.mode == 2'd0) ? io_bus.ext_data : '0;
      end else if (w_wait_last) begin
        r_valid <= 1'b1;
        r_data  <= w_rom_frame;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.rom_addr   = w_rom_addr;
  assign io_bus.rom_ck     = w_rom_ck;
  assign io_bus.data_out   = r_data;
  assign io_bus.data_valid = r_valid;
  assign io_bus.overrun    = r_overrun;
  assign io_bus.st         = r_st;

endmodule
